// File: rtl/quat_requant_if.sv
// Handshake bundle between the quaternion requantizer and its producer/consumer.
// The master drives operands and output-ready; the slave (quat_requant) drives results.
interface quat_requant_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  r1;
  logic signed [IN_W-1:0]  r2;
  logic signed [IN_W-1:0]  r3;
  logic signed [IN_W-1:0]  r4;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] q1;
  logic signed [OUT_W-1:0] q2;
  logic signed [OUT_W-1:0] q3;
  logic signed [OUT_W-1:0] q4;
  logic [2*OUT_W:0]        norm_sq;
  logic                    sat;

  modport master (
    output in_valid, r1, r2, r3, r4, out_ready,
    input  in_ready, out_valid, q1, q2, q3, q4, norm_sq, sat
  );

  modport slave (
    input  in_valid, r1, r2, r3, r4, out_ready,
    output in_ready, out_valid, q1, q2, q3, q4, norm_sq, sat
  );
endinterface

// File: rtl/quat_requant.sv
// Requantizes four signed quaternion product components with round/saturate and
// accumulates their squared norm on one shared multiplier. Macro QREQ_NORM_EN enables the norm stage.
module quat_requant #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 14
) (
  input logic           clk,
  input logic           rst_n,
  quat_requant_if.slave bus
);

  localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic signed [IN_W:0] RND =
    (FRAC_BITS > 0) ? ((IN_W+1)'(1) << RND_SH) : (IN_W+1)'(0);
  localparam logic signed [IN_W:0] Q_MAX = (IN_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [IN_W:0] Q_MIN = ~Q_MAX;

  typedef enum logic [1:0] {
    IDLE,
`ifdef QREQ_NORM_EN
    NORM,
`endif
    DONE
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    in_ready;
  logic                    out_valid;
  logic                    accept;
  logic signed [OUT_W-1:0] q_r [4];
  logic                    sat_r;
  logic [OUT_W:0]          rq1;
  logic [OUT_W:0]          rq2;
  logic [OUT_W:0]          rq3;
  logic [OUT_W:0]          rq4;

  // Returns {clip, value}; rounding is half toward +inf via add-then-floor.
  function automatic logic [OUT_W:0] requant(input logic signed [IN_W-1:0] r);
    logic signed [IN_W:0] t;
    t = {r[IN_W-1], r};
    t = (t + RND) >>> FRAC_BITS;
    if (t > Q_MAX)
      return {1'b1, Q_MAX[OUT_W-1:0]};
    else if (t < Q_MIN)
      return {1'b1, Q_MIN[OUT_W-1:0]};
    else
      return {1'b0, t[OUT_W-1:0]};
  endfunction

  assign rq1    = requant(bus.r1);
  assign rq2    = requant(bus.r2);
  assign rq3    = requant(bus.r3);
  assign rq4    = requant(bus.r4);
  assign accept = bus.in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

`ifdef QREQ_NORM_EN
  logic [1:0]              cnt;
  logic [2*OUT_W:0]        norm_r;
  logic signed [2*OUT_W-1:0] sq;

  assign sq = q_r[cnt] * q_r[cnt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      norm_r <= '0;
    end else if (accept) begin
      cnt    <= '0;
      norm_r <= '0;
    end else if (state == NORM) begin
      cnt    <= cnt + 2'd1;
      norm_r <= norm_r + {1'b0, sq};
    end
  end

  assign bus.norm_sq = norm_r;
`else
  assign bus.norm_sq = '0;
`endif

  always_comb begin
    state_next = state;
    case (state)
`ifdef QREQ_NORM_EN
      IDLE: if (bus.in_valid) state_next = NORM;
      NORM: if (cnt == 2'd3)  state_next = DONE;
      DONE: if (bus.out_ready) state_next = bus.in_valid ? NORM : IDLE;
`else
      IDLE: if (bus.in_valid) state_next = DONE;
      DONE: if (bus.out_ready) state_next = bus.in_valid ? DONE : IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // In DONE the slot frees up in the same cycle the consumer takes the result.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      DONE: begin
        in_ready  = bus.out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r   <= '{default: '0};
      sat_r <= 1'b0;
    end else if (accept) begin
      q_r[0] <= rq1[OUT_W-1:0];
      q_r[1] <= rq2[OUT_W-1:0];
      q_r[2] <= rq3[OUT_W-1:0];
      q_r[3] <= rq4[OUT_W-1:0];
      sat_r  <= rq1[OUT_W] | rq2[OUT_W] | rq3[OUT_W] | rq4[OUT_W];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.q1        = q_r[0];
  assign bus.q2        = q_r[1];
  assign bus.q3        = q_r[2];
  assign bus.q4        = q_r[3];
  assign bus.sat       = sat_r;

endmodule
